// File: rtl/path_payoff_accum.sv
// rtl/path_payoff_accum.sv - European call/put payoff accumulator over a fixed number of simulated paths
module path_payoff_accum #(
    parameter int DATA_W     = 12,
    parameter int STEPS      = 16,
    parameter int PATHS_LOG2 = 8,
    localparam int ACC_W     = DATA_W + PATHS_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     strike,
    input  logic                  is_put,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_path,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_W-1:0]      sum,
    output logic [DATA_W-1:0]     mean,
    output logic [PATHS_LOG2:0]   path_cnt
);

    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);
    localparam logic [PATHS_LOG2:0] LAST_PATH = (PATHS_LOG2 + 1)'((1 << PATHS_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [SW-1:0]     step_cnt;
    logic [DATA_W-1:0] k_q;
    logic              put_q;
    logic [DATA_W-1:0] payoff;

    // Payoff of the current sample; only consumed on the terminal step of a path.
    always_comb begin
        payoff = '0;
        if (put_q) begin
            if (k_q > in_path) payoff = k_q - in_path;
        end else begin
            if (in_path > k_q) payoff = in_path - k_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            path_cnt <= '0;
            step_cnt <= '0;
            k_q      <= '0;
            put_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A sample arriving alongside start belongs to no run.
                    if (start) begin
                        k_q      <= strike;
                        put_q    <= is_put;
                        sum      <= '0;
                        path_cnt <= '0;
                        step_cnt <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (step_cnt == LAST_STEP) begin
                            step_cnt <= '0;
                            sum      <= sum + ACC_W'(payoff);
                            path_cnt <= path_cnt + 1'b1;
                            if (path_cnt == LAST_PATH) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mean = sum[ACC_W-1:PATHS_LOG2];

endmodule

// File: tb/tb_path_payoff_accum.sv
// tb/tb_path_payoff_accum.sv - scoreboard bench for path_payoff_accum (4 steps x 4 paths)
module tb_path_payoff_accum;

    localparam int DATA_W     = 12;
    localparam int STEPS      = 4;
    localparam int PATHS_LOG2 = 2;
    localparam int ACC_W      = DATA_W + PATHS_LOG2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [DATA_W-1:0]   strike = '0;
    logic                is_put = 1'b0;
    logic                in_valid = 1'b0;
    logic [DATA_W-1:0]   in_path = '0;
    logic                busy;
    logic                done;
    logic [ACC_W-1:0]    sum;
    logic [DATA_W-1:0]   mean;
    logic [PATHS_LOG2:0] path_cnt;

    path_payoff_accum #(
        .DATA_W(DATA_W), .STEPS(STEPS), .PATHS_LOG2(PATHS_LOG2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .strike(strike), .is_put(is_put),
        .in_valid(in_valid), .in_path(in_path), .busy(busy), .done(done),
        .sum(sum), .mean(mean), .path_cnt(path_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {int s; int m; int p; int c;} exp_t;
    exp_t q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_cyc = 0;
    int fill_v = 0;
    int term[4] = '{150, 80, 100, 300};
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every rising edge of done retires one expected run result.
    always @(negedge clk) begin
        if (done === 1'b1 && prev_done === 1'b0) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("run_sum", int'(sum), e.s);
                check("run_mean", int'(mean), e.m);
                check("run_path_cnt", int'(path_cnt), e.p);
                check("done_cycle", cyc, e.c);
                check("busy_at_done", int'(busy), 0);
            end
        end
        prev_done = done;
    end

    function automatic int sval(input int i);
        if (fill_v != 0) return fill_v;
        if (i % 4 == 3) return term[i / 4];
        return 200 + i * 37;
    endfunction

    task automatic start_run(input int k, input bit put, input bit with_valid);
        strike   = DATA_W'(k);
        is_put   = put;
        start    = 1'b1;
        in_valid = with_valid;
        in_path  = 12'd4000;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic do_samples(input int first, input int last, input int gap_max, input int pulse_at);
        for (int i = first; i <= last; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (i == pulse_at) begin
                strike = 12'd500;
                start  = 1'b1;
                @(posedge clk); #1;
                start  = 1'b0;
            end
            repeat (g) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_path  = DATA_W'(sval(i));
            @(posedge clk); #1;
            last_cyc = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic finish_run(input int es, input int em);
        int n;
        q.push_back('{es, em, 4, last_cyc});
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            check("done_timeout", 0, 1);
            q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_mean", int'(mean), 0);
        check("rst_path_cnt", int'(path_cnt), 0);

        // Call run; the sample presented with start must be dropped.
        start_run(100, 0, 1);
        check("start_busy", int'(busy), 1);
        do_samples(0, 3, 0, -1);
        check("path1_sum", int'(sum), 50);
        check("path1_cnt", int'(path_cnt), 1);
        do_samples(4, 15, 0, -1);
        finish_run(250, 62);

        // Put run from DONE.
        start_run(100, 1, 0);
        do_samples(0, 15, 0, -1);
        finish_run(20, 5);

        // Restart from DONE with K=0 call: done drops, sum clears.
        start_run(0, 0, 0);
        check("restart_done", int'(done), 0);
        check("restart_busy", int'(busy), 1);
        check("restart_sum", int'(sum), 0);
        check("restart_path_cnt", int'(path_cnt), 0);
        do_samples(0, 15, 0, -1);
        finish_run(630, 157);

        // Gapped call run with an ignored start pulse carrying K=500.
        start_run(100, 0, 0);
        do_samples(0, 15, 5, 6);
        finish_run(250, 62);

        // Abort after the 9th sample, then a clean put run.
        start_run(100, 0, 0);
        do_samples(0, 8, 0, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_sum", int'(sum), 0);
        check("abort_mean", int'(mean), 0);
        check("abort_path_cnt", int'(path_cnt), 0);
        start_run(100, 1, 0);
        do_samples(0, 15, 0, -1);
        finish_run(20, 5);

        // Extremes: full-scale samples.
        fill_v = 4095;
        start_run(0, 0, 0);
        do_samples(0, 15, 0, -1);
        finish_run(16380, 4095);
        start_run(4095, 1, 0);
        do_samples(0, 15, 0, -1);
        finish_run(0, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/path_payoff_accum.md
Name: path_payoff_accum

Overview:
- Consumer end of the path-generator output stream (valid/path, one price sample per valid cycle, unsigned integer price).
- Counts time steps per path and takes the terminal price of each path.
- Computes the European call or put payoff against a latched strike and accumulates it over 2^PATHS_LOG2 paths.
- Presents the payoff sum and the mean (sum >> PATHS_LOG2) to the pricing top level.

Parameters:
- DATA_W, 12, width of price samples, strike and mean.
- STEPS, 16, valid samples per path; the STEPS-th sample is the terminal price. Must be ≥ 1.
- PATHS_LOG2, 8, log2 of the number of paths per run (default 256 paths).
- ACC_W, DATA_W+PATHS_LOG2, accumulator width; derived, do not override.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, reset; synchronous, active-high.
- start, input, 1, begin a run; sampled in IDLE or DONE only.
- strike, input, DATA_W, strike price K; latched on accepted start.
- is_put, input, 1, 0 = call payoff max(S-K,0), 1 = put payoff max(K-S,0); latched on accepted start.
- in_valid, input, 1, sample-valid from the path generator.
- in_path, input, DATA_W, unsigned price sample.
- busy, output, 1, high in RUN.
- done, output, 1, high in DONE; held until the next accepted start or rst.
- sum, output, ACC_W, accumulated payoff.
- mean, output, DATA_W, sum[ACC_W-1:PATHS_LOG2].
- path_cnt, output, PATHS_LOG2+1, number of completed paths in the current run.

Behaviour:
- Reset (rst=1 at a clk edge, any state including mid-run):
  - state=IDLE; busy=0, done=0, sum=0, mean=0, path_cnt=0.
  - step_cnt=0; latched strike=0, is_put=0.
- FSM states IDLE, RUN, DONE; all outputs registered.
- IDLE:
  - in_valid ignored.
  - start=1 → latch strike/is_put, clear sum, path_cnt and step_cnt; next state RUN.
- RUN, each cycle with in_valid=1:
  - If step_cnt < STEPS-1: step_cnt++.
  - If step_cnt == STEPS-1 (terminal sample):
    - payoff = is_put ? (K>S ? K-S : 0) : (S>K ? S-K : 0), computed at DATA_W width, zero-extended.
    - sum += payoff; path_cnt++; step_cnt=0.
  - Updated sum and path_cnt are visible the cycle after the terminal sample.
- RUN, in_valid=0: hold all state. Gaps of any length are allowed between samples.
- RUN, start=1: ignored; the run continues and latched strike/is_put are unchanged.
- RUN → DONE: in the same edge that accepts the terminal sample of path 2^PATHS_LOG2 (path_cnt becomes 2^PATHS_LOG2).
  - done=1 and busy=0 the cycle after that terminal sample.
  - sum and mean are final and stable in that same cycle.
- DONE:
  - Hold sum, mean, path_cnt; in_valid ignored.
  - start=1 → same actions as start in IDLE, and done drops the next cycle.
- start and in_valid high in the same IDLE/DONE cycle: start is accepted; that sample is not counted.
- No overflow is possible: max sum = (2^DATA_W-1)·2^PATHS_LOG2 < 2^ACC_W. No saturation logic.
- Mean is truncated (floor); no rounding.
- Zero-valued samples are counted like any other sample. Upstream never asserts valid with a zero price.

Test Plan:
- Call run, STEPS=4, PATHS_LOG2=2, K=100, is_put=0; terminal samples 150, 80, 100, 300, non-terminal samples arbitrary → sum=250, mean=62, path_cnt=4. done rises exactly 1 cycle after the 16th valid sample.
- Put run, same samples, K=100, is_put=1 → sum=20, mean=5. Then restart from DONE with K=0, call → done drops next cycle and sum restarts from 0.
- Random 0–5 cycle gaps inserted on in_valid during the call run → identical sum=250. done timing still tied to the 16th accepted sample.
- start pulsed during RUN with K=500 → ignored; result still computed with K=100. start during IDLE with in_valid=1 → that sample is not counted.
- rst asserted after the 9th sample → next cycle all outputs are 0 and state is IDLE. A new run gives correct results with no residue from the aborted run.
- Extreme values, PATHS_LOG2=2, K=0, call, all samples 4095 → sum=16380, mean=4095. Put with K=4095, all samples 4095 → sum=0.
